// File: rtl/loopback_pkg.sv
// Shared types and constants for the HPIO loopback counter pattern (checker and counter_datagen).
// No logic, no latency, no flow control.
package loopback_pkg;

   localparam int WORD_W = 8;

   // Step between consecutive words of the transmitted counter pattern.
   localparam logic [WORD_W-1:0] PAT_INC = 8'd1;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
      return w + PAT_INC;
   endfunction

endpackage

// File: rtl/rx_bitslip.sv
// Bit-slip aligner: picks an 8-bit window from {data_in, prev_word}, registered output, latency 1.
// No backpressure; candidate/cand_valid are exposed combinationally for same-cycle checking.
module rx_bitslip
   import loopback_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [2:0]        slip,
   output logic [WORD_W-1:0] cand,
   output logic              cand_valid,
   output logic [WORD_W-1:0] aligned_data,
   output logic              aligned_valid
);

   logic [WORD_W-1:0]   prev_word;
   logic                have_prev;
   logic [2*WORD_W-1:0] window;

   assign window     = {data_in, prev_word};
   assign cand       = window[slip +: WORD_W];
   // The very first word after reset has no predecessor to slip against.
   assign cand_valid = data_valid & have_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_word     <= '0;
         have_prev     <= 1'b0;
         aligned_data  <= '0;
         aligned_valid <= 1'b0;
      end else begin
         aligned_valid <= cand_valid;
         if (cand_valid) aligned_data <= cand;
         if (data_valid) begin
            prev_word <= data_in;
            have_prev <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rx_loopback_checker.sv
// Finds the bit-slip giving a mod-256 up-count, locks, then checks each word against a free-running counter.
// Latency 1 from data_in to aligned/pulse outputs; no backpressure, idle cycles (data_valid=0) only clear pulses.
module rx_loopback_checker
   import loopback_pkg::*;
#(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 8,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] data_in,
   input  logic              data_valid,
   input  logic              clr_cnt,
   output logic [WORD_W-1:0] aligned_data,
   output logic              aligned_valid,
   output logic [2:0]        slip,
   output logic              locked,
   output logic              err_pulse,
   output logic              lost_lock,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
   localparam logic [7:0]       LOSS_LAST = 8'(LOSS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic [WORD_W-1:0] cand;
   logic              cand_valid;
   logic [WORD_W-1:0] last;
   logic [WORD_W-1:0] exp_word;
   logic              have_last;
   logic [7:0]        match_cnt;
   logic [7:0]        miss_cnt;
   logic              mism;

   rx_bitslip u_bitslip (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .slip          (slip),
      .cand          (cand),
      .cand_valid    (cand_valid),
      .aligned_data  (aligned_data),
      .aligned_valid (aligned_valid)
   );

   assign locked = (state == LOCKED);
   assign mism   = (cand != exp_word);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= SEARCH;
         slip      <= 3'd0;
         last      <= '0;
         exp_word  <= '0;
         have_last <= 1'b0;
         match_cnt <= 8'd0;
         miss_cnt  <= 8'd0;
         err_pulse <= 1'b0;
         lost_lock <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         lost_lock <= 1'b0;
         if (cand_valid) begin
            if (state == SEARCH) begin
               if (!have_last) begin
                  last      <= cand;
                  have_last <= 1'b1;
               end else if (cand == next_word(last)) begin
                  last      <= cand;
                  match_cnt <= match_cnt + 8'd1;
                  if (match_cnt == LOCK_LAST) begin
                     state    <= LOCKED;
                     exp_word <= next_word(cand);
                     miss_cnt <= 8'd0;
                  end
               end else begin
                  slip      <= slip + 3'd1;
                  match_cnt <= 8'd0;
                  have_last <= 1'b0;
               end
            end else begin
               // exp_word free-runs: a dropped or duplicated word shows up as a run of errors.
               exp_word <= next_word(exp_word);
               if (!mism) begin
                  miss_cnt <= 8'd0;
               end else begin
                  err_pulse <= 1'b1;
                  miss_cnt  <= miss_cnt + 8'd1;
                  if (miss_cnt == LOSS_LAST) begin
                     state     <= SEARCH;
                     lost_lock <= 1'b1;
                     match_cnt <= 8'd0;
                     have_last <= 1'b0;
                     miss_cnt  <= 8'd0;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt  <= '0;
         word_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt  <= '0;
         word_cnt <= '0;
      end else if (cand_valid && state == LOCKED) begin
         if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_ONE;
         if (mism && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_rx_loopback_checker.sv
// Directed bench for rx_loopback_checker: lock at slip 0 and 5, single error, lock loss, idle gaps, resets.
module tb_rx_loopback_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic        data_valid = 1'b0;
   logic        clr_cnt = 1'b0;
   logic [7:0]  aligned_data;
   logic        aligned_valid;
   logic [2:0]  slip;
   logic        locked;
   logic        err_pulse;
   logic        lost_lock;
   logic [31:0] err_cnt;
   logic [31:0] word_cnt;

   int          tests = 0;
   int          fails = 0;
   int          err_pulses = 0;
   int          lost_pulses = 0;
   logic [7:0]  prev_log = 8'h00;
   logic [7:0]  exp_al = 8'h00;
   logic [7:0]  cnt = 8'h00;
   bit          have_prev_m = 1'b0;
   bit          exp_vld = 1'b0;
   bit          rot = 1'b0;

   rx_loopback_checker dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .clr_cnt       (clr_cnt),
      .aligned_data  (aligned_data),
      .aligned_valid (aligned_valid),
      .slip          (slip),
      .locked        (locked),
      .err_pulse     (err_pulse),
      .lost_lock     (lost_lock),
      .err_cnt       (err_cnt),
      .word_cnt      (word_cnt)
   );

   always #5 clk = ~clk;

   // Drive one logical word (or an idle cycle); rot selects a stream rotated so slip 5 recovers it.
   task automatic send(input logic [7:0] l, input bit v, input bit c);
      @(negedge clk);
      clr_cnt    = c;
      data_valid = v;
      if (v) data_in = rot ? {l[2:0], prev_log[7:3]} : l;
      else   data_in = 8'h5A;
      @(posedge clk);
      #1;
      if (err_pulse) err_pulses++;
      if (lost_lock) lost_pulses++;
      if (v) begin
         exp_al      = prev_log;
         exp_vld     = have_prev_m;
         prev_log    = l;
         have_prev_m = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      data_valid = 1'b0;
      clr_cnt    = 1'b0;
      rst        = 1'b0;
      @(negedge clk);
      rst         = 1'b1;
      prev_log    = 8'h00;
      have_prev_m = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({aligned_valid, locked, err_pulse, lost_lock, slip} !== 7'd0) begin
         fails++; $display("FAIL reset_flags: got %b want 0", {aligned_valid, locked, err_pulse, lost_lock, slip});
      end
      tests++;
      if (aligned_data !== 8'h00) begin
         fails++; $display("FAIL reset_data: got %h want 00", aligned_data);
      end
      tests++;
      if (err_cnt !== 32'd0 || word_cnt !== 32'd0) begin
         fails++; $display("FAIL reset_cnt: got err=%0d words=%0d want 0/0", err_cnt, word_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lock_slip0();
      rot = 1'b0;
      for (int i = 0; i < 28; i++) begin
         send(8'(i), 1'b1, 1'b0);
         tests++;
         if (aligned_valid !== exp_vld || (exp_vld && aligned_data !== exp_al)) begin
            fails++; $display("FAIL slip0_data[%0d]: got v=%b d=%h want v=%b d=%h", i, aligned_valid, aligned_data, exp_vld, exp_al);
         end
         tests++;
         if (locked !== (i >= 17)) begin
            fails++; $display("FAIL slip0_locked[%0d]: got %b want %b", i, locked, (i >= 17));
         end
      end
      tests++;
      if (slip !== 3'd0 || err_cnt !== 32'd0 || word_cnt !== 32'd10) begin
         fails++; $display("FAIL slip0_status: got slip=%0d err=%0d words=%0d want 0/0/10", slip, err_cnt, word_cnt);
      end
   endtask

   task automatic test_single_err();
      err_pulses = 0;
      for (int v = 28; v <= 8'h40; v++) begin
         send((v == 8'h37) ? 8'hAA : 8'(v), 1'b1, 1'b0);
         tests++;
         if (err_pulse !== (exp_al == 8'hAA) || aligned_data !== exp_al) begin
            fails++; $display("FAIL single_err_word %h: got pulse=%b d=%h want pulse=%b", exp_al, err_pulse, aligned_data, (exp_al == 8'hAA));
         end
      end
      tests++;
      if (err_pulses != 1 || err_cnt !== 32'd1 || locked !== 1'b1 || word_cnt !== 32'd47) begin
         fails++; $display("FAIL single_err_summary: got pulses=%0d err=%0d locked=%b words=%0d want 1/1/1/47", err_pulses, err_cnt, locked, word_cnt);
      end
   endtask

   task automatic test_rotated();
      do_reset();
      rot = 1'b1;
      cnt = 8'h00;
      for (int n = 0; n < 100 && locked !== 1'b1; n++) begin
         send(cnt, 1'b1, 1'b0);
         cnt++;
      end
      tests++;
      if (locked !== 1'b1 || slip !== 3'd5) begin
         fails++; $display("FAIL rot_lock: got locked=%b slip=%0d want 1/5", locked, slip);
      end
      // 300 further words cover 0x41->0x42 and the 0xFF->0x00 wrap.
      for (int n = 0; n < 300; n++) begin
         send(cnt, 1'b1, 1'b0);
         cnt++;
         tests++;
         if (aligned_data !== exp_al || err_pulse !== 1'b0 || locked !== 1'b1) begin
            fails++; $display("FAIL rot_stream[%0d]: got d=%h pulse=%b locked=%b want d=%h 0 1", n, aligned_data, err_pulse, locked, exp_al);
         end
      end
      tests++;
      if (err_cnt !== 32'd0) begin
         fails++; $display("FAIL rot_err_cnt: got %0d want 0", err_cnt);
      end
   endtask

   task automatic test_loss();
      for (int n = 0; n < 256 && cnt != 8'h60; n++) begin
         send(cnt, 1'b1, 1'b0);
         cnt++;
      end
      send(8'h00, 1'b0, 1'b1);
      tests++;
      if (err_cnt !== 32'd0 || word_cnt !== 32'd0 || aligned_valid !== 1'b0) begin
         fails++; $display("FAIL loss_clr: got err=%0d words=%0d v=%b want 0/0/0", err_cnt, word_cnt, aligned_valid);
      end
      err_pulses  = 0;
      lost_pulses = 0;
      for (int z = 0; z < 8; z++) begin
         send(8'h00, 1'b1, 1'b0);
         cnt++;
         tests++;
         if (err_pulse !== (z != 0) || locked !== 1'b1 || lost_lock !== 1'b0) begin
            fails++; $display("FAIL loss_zero[%0d]: got pulse=%b locked=%b lost=%b want %b 1 0", z, err_pulse, locked, lost_lock, (z != 0));
         end
      end
      send(cnt, 1'b1, 1'b0);
      cnt++;
      tests++;
      if (err_pulse !== 1'b1 || lost_lock !== 1'b1 || locked !== 1'b0) begin
         fails++; $display("FAIL loss_eighth: got pulse=%b lost=%b locked=%b want 1 1 0", err_pulse, lost_lock, locked);
      end
      tests++;
      if (err_cnt !== 32'd8 || slip !== 3'd5 || err_pulses != 8) begin
         fails++; $display("FAIL loss_status: got err=%0d slip=%0d pulses=%0d want 8/5/8", err_cnt, slip, err_pulses);
      end
      for (int j = 2; j <= 18; j++) begin
         send(cnt, 1'b1, 1'b0);
         cnt++;
         tests++;
         if (locked !== (j == 18)) begin
            fails++; $display("FAIL relock[%0d]: got %b want %b", j, locked, (j == 18));
         end
      end
      tests++;
      if (lost_pulses != 1 || slip !== 3'd5) begin
         fails++; $display("FAIL relock_status: got lost=%0d slip=%0d want 1/5", lost_pulses, slip);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      #2;
      data_valid = 1'b0;
      rst        = 1'b0;
      #1;
      tests++;
      if (slip !== 3'd0 || locked !== 1'b0 || aligned_valid !== 1'b0) begin
         fails++; $display("FAIL mid_rst_async: got slip=%0d locked=%b v=%b want 0 0 0", slip, locked, aligned_valid);
      end
      tests++;
      if (err_cnt !== 32'd0 || word_cnt !== 32'd0) begin
         fails++; $display("FAIL mid_rst_cnt: got err=%0d words=%0d want 0/0", err_cnt, word_cnt);
      end
      @(negedge clk);
      rst         = 1'b1;
      prev_log    = 8'h00;
      have_prev_m = 1'b0;
      rot         = 1'b0;
      for (int i = 0; i < 18; i++) begin
         send(8'(8'h90 + i), 1'b1, 1'b0);
         tests++;
         if (aligned_valid !== exp_vld || locked !== (i == 17)) begin
            fails++; $display("FAIL mid_rst_relock[%0d]: got v=%b locked=%b want %b %b", i, aligned_valid, locked, exp_vld, (i == 17));
         end
      end
      tests++;
      if (slip !== 3'd0) begin
         fails++; $display("FAIL mid_rst_slip: got %0d want 0", slip);
      end
   endtask

   task automatic test_valid_toggle();
      do_reset();
      rot = 1'b0;
      for (int i = 0; i < 19; i++) begin
         send(8'(8'hC0 + i), 1'b1, 1'b0);
         tests++;
         if (locked !== (i >= 17)) begin
            fails++; $display("FAIL toggle_locked[%0d]: got %b want %b", i, locked, (i >= 17));
         end
         send(8'h00, 1'b0, 1'b0);
         tests++;
         if (aligned_valid !== 1'b0 || err_pulse !== 1'b0) begin
            fails++; $display("FAIL toggle_idle[%0d]: got v=%b pulse=%b want 0 0", i, aligned_valid, err_pulse);
         end
      end
      send(8'hAA, 1'b1, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'hD4, 1'b1, 1'b1);
      tests++;
      if (err_pulse !== 1'b1 || err_cnt !== 32'd0 || word_cnt !== 32'd0 || aligned_data !== 8'hAA) begin
         fails++; $display("FAIL toggle_clr_err: got pulse=%b err=%0d words=%0d d=%h want 1/0/0/aa", err_pulse, err_cnt, word_cnt, aligned_data);
      end
      send(8'h00, 1'b0, 1'b0);
      send(8'hD5, 1'b1, 1'b0);
      tests++;
      if (err_pulse !== 1'b0 || err_cnt !== 32'd0 || word_cnt !== 32'd1 || locked !== 1'b1) begin
         fails++; $display("FAIL toggle_after: got pulse=%b err=%0d words=%0d locked=%b want 0/0/1/1", err_pulse, err_cnt, word_cnt, locked);
      end
   endtask

   initial begin
      test_reset();
      test_lock_slip0();
      test_single_err();
      test_rotated();
      test_loss();
      test_mid_reset();
      test_valid_toggle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rx_loopback_checker.md
Name: rx_loopback_checker

Overview:
- Sits directly downstream of the HPIO RX deserialiser, in the clk_80m domain.
- Consumes the 8-bit parallel data_to_fabric word that carries the transmitted incrementing-counter pattern, qualified by the RX FIFO read-valid.
- Finds the bit-slip offset at which the stream forms a mod-256 up-count and declares lock.
- While locked, checks every word against a free-running expected counter, and exposes aligned data, lock status and error/word counters for ILA and VIO probing.

Parameters:
- LOCK_CNT, 16, consecutive in-sequence words needed in SEARCH before LOCKED (range 2..255).
- LOSS_CNT, 8, consecutive mismatching words in LOCKED that force a return to SEARCH (range 1..255).
- CNT_W, 32, width of the err_cnt and word_cnt counters.

Ports:
- clk  in  1  checker clock (clk_80m, same as the RX FIFO read clock).
- rst  in  1  asynchronous, active-low reset.
- data_in  in  8  raw deserialised word (data_to_fabric for the RX data pin).
- data_valid  in  1  data_in qualifier (fifo_rd_data_valid).
- clr_cnt  in  1  synchronous clear of err_cnt and word_cnt.
- aligned_data  out  8  bit-slipped word.
- aligned_valid  out  1  aligned_data qualifier.
- slip  out  3  current bit offset under test or locked.
- locked  out  1  high in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word in LOCKED.
- lost_lock  out  1  one-cycle pulse on the LOCKED->SEARCH transition.
- err_cnt  out  CNT_W  saturating count of mismatched words.
- word_cnt  out  CNT_W  saturating count of checked words.

Behaviour:
- Reset (rst=0, async): all outputs 0, state=SEARCH, prev_word=0, have_prev=0, have_last=0, match_cnt=0, miss_cnt=0.
- Data path:
  - On data_valid: prev_word<=data_in and have_prev<=1.
  - Window W={data_in,prev_word} (16 bits); candidate A=W[slip+7:slip].
  - If data_valid and have_prev: aligned_data<=A and aligned_valid<=1 the next cycle (latency 1). Otherwise aligned_valid<=0.
  - The first valid word after reset produces no output.
- Cycles with data_valid=0 change nothing except clearing aligned_valid and the pulse outputs.
- SEARCH (locked=0), per aligned word:
  - If have_last=0: last<=A, have_last<=1.
  - Else if A==last+1 (mod 256): match_cnt++ and last<=A.
    - When match_cnt reaches LOCK_CNT-1 on a match: go to LOCKED, exp<=A+1, miss_cnt<=0.
  - Else (mismatch): slip<=slip+1 (7 wraps to 0), match_cnt<=0, have_last<=0.
  - 255->0 counts as in-sequence.
- LOCKED (locked=1), per aligned word:
  - word_cnt++ (saturating). exp<=exp+1 on every word, match or not (exp is free-running, never resynced to data).
  - If A==exp: miss_cnt<=0.
  - Else: err_pulse=1, err_cnt++ (saturating), miss_cnt++.
    - When miss_cnt reaches LOSS_CNT on a mismatch: go to SEARCH, lost_lock=1, match_cnt<=0, have_last<=0; slip is held.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_cnt has priority over increments in the same cycle. It does not affect state or slip.
- Pulse timing: err_pulse and lost_lock are registered and coincide with the aligned_valid of the offending word.
- Mid-operation reset returns to SEARCH with slip=0 immediately. No partial state survives.
- Latency from data_in to locked: LOCK_CNT+1 valid words at the correct slip, plus 1 cycle.

Decomposition:
- Shared package (loopback_pkg):
  - State enum {SEARCH, LOCKED}.
  - Constant WORD_W=8.
  - Counter-pattern increment constant (1), shared with counter_datagen.
- One natural sub-module: rx_bitslip (prev-word register, window mux, aligned output register, 1-cycle latency).
- The FSM, comparators and counters stay in the top of the block.

Test Plan:
- Counter 0x00..0xFF at slip 0, data_valid always 1, LOCK_CNT=16 -> locked rises after the 17th aligned word, slip=0, err_cnt=0, word_cnt increments per word.
- Stream rotated by 5 bits -> slip steps 0->5 and locked asserts. Aligned_data then carries the uninterrupted up-count (e.g. 0x41 followed by 0x42). Wrap 0xFF->0x00 produces no error.
- While locked, corrupt one word (0x37 replaced by 0xAA) -> exactly one err_pulse, err_cnt=1, locked stays 1, and the next word 0x38 matches.
- While locked, replace 8 consecutive words with 0x00 (LOSS_CNT=8) -> err_cnt=8, lost_lock pulses once on the 8th mismatch, locked=0, slip unchanged. Relock after 17 clean words.
- data_valid toggled 1010…, with clr_cnt pulsed in the same cycle as an error -> lock behaviour identical to continuous valid, and err_cnt=0 after the clear.
- Assert rst low mid-LOCKED for one cycle -> all outputs 0 asynchronously, slip=0, and the lock sequence restarts.
